conv_mac_13: RTL and testbench

//  Multiply-accumulate stage for conv layer 13. Runs directly downstream of the layer-13 weight streamer.

---
 rtl/conv_mac_13.sv | 118 +++++++++++
 tb/tb_conv_mac_13.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_mac_13.sv
// Conv layer 13 multiply-accumulate: pops paired activation/coefficient words, sums TAPS products,
// pushes one rescaled result per window. Define CONV_MAC_SAT_EN to saturate the result instead of wrapping it.
module conv_mac_13 #(
   parameter int DATA_W = 16,
   parameter int ACC_W  = 40,
   parameter int OUT_W  = 16,
   parameter int TAPS   = 9,
   parameter int SHIFT  = 8
) (
   input  logic              ap_clk,
   input  logic              ap_rst,
   input  logic [DATA_W-1:0] input_V_dout,
   input  logic              input_V_empty_n,
   output logic              input_V_read,
   input  logic [DATA_W-1:0] weight_V_dout,
   input  logic              weight_V_empty_n,
   output logic              weight_V_read,
   output logic [OUT_W-1:0]  output_V_din,
   input  logic              output_V_full_n,
   output logic              output_V_write
);

   // Handshake: a pop happens on any cycle where the matching *_read is high at the rising edge
   // (data on *_dout is consumed that edge); a push happens on any cycle where output_V_write is high.
   typedef enum logic [1:0] {S_ACC = 2'd0, S_FLUSH = 2'd1, S_OUT = 2'd2} state_t;

   localparam int CNT_W  = (TAPS > 2) ? $clog2(TAPS) : 1;
   localparam int PROD_W = 2 * DATA_W;
   localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(TAPS - 1);

   state_t                    state_q, state_d;
   logic [CNT_W-1:0]          tap_cnt_q, tap_cnt_d;
   logic signed [PROD_W-1:0]  prod_q, prod_d;
   logic                      prod_vld_q, prod_vld_d;
   logic signed [ACC_W-1:0]   acc_q, acc_d;
   logic [OUT_W-1:0]          out_q, out_d;

   logic                      fire;
   logic signed [PROD_W-1:0]  prod_mul;
   logic signed [ACC_W-1:0]   acc_sum;
   logic signed [ACC_W-1:0]   scaled;
   logic [OUT_W-1:0]          narrowed;

   // State register
   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         state_q    <= S_ACC;
         tap_cnt_q  <= '0;
         prod_q     <= '0;
         prod_vld_q <= 1'b0;
         acc_q      <= '0;
         out_q      <= '0;
      end else begin
         state_q    <= state_d;
         tap_cnt_q  <= tap_cnt_d;
         prod_q     <= prod_d;
         prod_vld_q <= prod_vld_d;
         acc_q      <= acc_d;
         out_q      <= out_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_ACC:   if (fire && (tap_cnt_q == LAST_TAP)) state_d = S_FLUSH;
         S_FLUSH: state_d = S_OUT;
         S_OUT:   if (output_V_full_n) state_d = S_ACC;
         default: state_d = S_ACC;
      endcase
   end

   assign fire     = (state_q == S_ACC) && input_V_empty_n && weight_V_empty_n;
   assign prod_mul = $signed(input_V_dout) * $signed(weight_V_dout);
   assign acc_sum  = acc_q + {{(ACC_W-PROD_W){prod_q[PROD_W-1]}}, prod_q};
   assign scaled   = acc_sum >>> SHIFT;

`ifdef CONV_MAC_SAT_EN
   localparam logic signed [ACC_W-1:0] OUT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] OUT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
   always_comb begin
      narrowed = OUT_W'(scaled);
      if (scaled > OUT_MAX)      narrowed = {1'b0, {(OUT_W-1){1'b1}}};
      else if (scaled < OUT_MIN) narrowed = {1'b1, {(OUT_W-1){1'b0}}};
   end
`else
   assign narrowed = OUT_W'(scaled);
`endif

   // Datapath: the flush cycle folds the final product straight into the result
   always_comb begin
      tap_cnt_d  = tap_cnt_q;
      prod_d     = prod_q;
      prod_vld_d = fire;
      acc_d      = acc_q;
      out_d      = out_q;
      if (fire) begin
         prod_d    = prod_mul;
         tap_cnt_d = (tap_cnt_q == LAST_TAP) ? '0 : tap_cnt_q + 1'b1;
      end
      if (state_q == S_FLUSH) begin
         out_d = narrowed;
         acc_d = '0;
      end else if (prod_vld_q) begin
         acc_d = acc_sum;
      end
   end

   // Outputs
   always_comb begin
      input_V_read   = fire && !ap_rst;
      weight_V_read  = fire && !ap_rst;
      output_V_write = (state_q == S_OUT) && output_V_full_n && !ap_rst;
      output_V_din   = out_q;
   end

endmodule

// File: tb/tb_conv_mac_13.sv
// Self-checking bench for conv_mac_13: two instances (SHIFT=0 and SHIFT=8) share stimulus and are
// compared against a window-sum reference model. Honours CONV_MAC_SAT_EN like the design.
module tb_conv_mac_13;

   logic        clk = 1'b0;
   logic        ap_rst = 1'b1;
   logic [15:0] input_V_dout = '0;
   logic        input_V_empty_n = 1'b0;
   logic [15:0] weight_V_dout = '0;
   logic        weight_V_empty_n = 1'b0;
   logic        output_V_full_n = 1'b1;

   logic        ir0, wr0, wo0, ir8, wr8, wo8;
   logic [15:0] din0, din8;

   int n_checks = 0;
   int n_err    = 0;
   int cyc      = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   conv_mac_13 #(.SHIFT(0)) dut0 (
      .ap_clk(clk), .ap_rst(ap_rst),
      .input_V_dout(input_V_dout), .input_V_empty_n(input_V_empty_n), .input_V_read(ir0),
      .weight_V_dout(weight_V_dout), .weight_V_empty_n(weight_V_empty_n), .weight_V_read(wr0),
      .output_V_din(din0), .output_V_full_n(output_V_full_n), .output_V_write(wo0)
   );

   conv_mac_13 #(.SHIFT(8)) dut8 (
      .ap_clk(clk), .ap_rst(ap_rst),
      .input_V_dout(input_V_dout), .input_V_empty_n(input_V_empty_n), .input_V_read(ir8),
      .weight_V_dout(weight_V_dout), .weight_V_empty_n(weight_V_empty_n), .weight_V_read(wr8),
      .output_V_din(din8), .output_V_full_n(output_V_full_n), .output_V_write(wo8)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference: sum the window in wide arithmetic, wrap to 40 bits, shift, then narrow.
   function automatic logic [15:0] scale_ref(input longint s, input int sh);
      longint w;
      longint v;
      w = (s <<< 24) >>> 24;
      v = w >>> sh;
`ifdef CONV_MAC_SAT_EN
      if (v > 32767)  return 16'h7fff;
      if (v < -32768) return 16'h8000;
`endif
      return v[15:0];
   endfunction

   logic [15:0] exp_q0[$];
   logic [15:0] exp_q8[$];
   longint      win_sum = 0;
   int          win_n = 0;
   int          last_pop_cyc = 0;
   int          last_gap = 0;
   int          writes0 = 0;
   logic [15:0] last_din0 = '0;
   logic [15:0] last_din8 = '0;
   logic [15:0] e;

   always @(negedge clk) begin
      if (ap_rst) begin
         check("rst_write", {wo0, wo8}, 2'b00);
         check("rst_read", {ir0, wr0, ir8, wr8}, 4'b0000);
         win_sum = 0;
         win_n = 0;
         exp_q0.delete();
         exp_q8.delete();
      end else begin
         if (ir0 || wr0) begin
            check("read_pair", {ir0, wr0}, 2'b11);
            check("read_ready", {input_V_empty_n, weight_V_empty_n}, 2'b11);
         end
         if (ir8 || wr8) check("read_pair8", {ir8, wr8}, 2'b11);
         if (ir0) begin
            win_sum += longint'($signed(input_V_dout)) * longint'($signed(weight_V_dout));
            win_n++;
            if (win_n == 9) begin
               exp_q0.push_back(scale_ref(win_sum, 0));
               exp_q8.push_back(scale_ref(win_sum, 8));
               win_sum = 0;
               win_n = 0;
               last_pop_cyc = cyc;
            end
         end
         if (wo0) begin
            writes0++;
            last_din0 = din0;
            last_gap = cyc - last_pop_cyc;
            check("latency_min", (last_gap >= 2), 1'b1);
            if (exp_q0.size() == 0) check("unexp_write0", 1'b1, 1'b0);
            else begin
               e = exp_q0.pop_front();
               check("din_s0", din0, e);
            end
         end
         if (wo8) begin
            last_din8 = din8;
            if (exp_q8.size() == 0) check("unexp_write8", 1'b1, 1'b0);
            else begin
               e = exp_q8.pop_front();
               check("din_s8", din8, e);
            end
         end
      end
   end

   logic [15:0] act_v[9];
   logic [15:0] wt_v[9];

   // mode 0: always ready; 1: weight toggles each cycle; 2: random empties and random full_n
   task automatic feed(input int n, input int mode);
      int idx = 0;
      int budget = 0;
      logic tog = 1'b0;
      while (idx < n && budget < 400) begin
         input_V_dout  = act_v[idx];
         weight_V_dout = wt_v[idx];
         input_V_empty_n  = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
         weight_V_empty_n = (mode == 1) ? tog : (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
         if (mode == 2) output_V_full_n = ($urandom_range(0, 3) != 0);
         tog = ~tog;
         @(negedge clk);
         if (ir0) idx++;
         @(posedge clk); #1;
         budget++;
      end
      input_V_empty_n  = 1'b0;
      weight_V_empty_n = 1'b0;
      if (idx < n) check("feed_timeout", idx, n);
   endtask

   task automatic drain();
      int budget = 0;
      output_V_full_n = 1'b1;
      while ((exp_q0.size() != 0 || exp_q8.size() != 0) && budget < 50) begin
         @(posedge clk); #1;
         budget++;
      end
      if (budget >= 50) check("drain_timeout", exp_q0.size(), 0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic load_const(input logic [15:0] a, input logic [15:0] w);
      for (int i = 0; i < 9; i++) begin
         act_v[i] = a;
         wt_v[i]  = w;
      end
   endtask

   int wbase;

   initial begin
      repeat (3) @(posedge clk);
      #1;
      ap_rst = 1'b0;
      @(negedge clk);
      check("reset_din0", din0, 16'h0000);
      check("reset_din8", din8, 16'h0000);
      check("reset_write", wo0, 1'b0);
      @(posedge clk); #1;

      // 1: ones times 1..9
      for (int i = 0; i < 9; i++) begin
         act_v[i] = 16'd1;
         wt_v[i]  = 16'(i + 1);
      end
      wbase = writes0;
      feed(9, 0);
      drain();
      check("t1_din", last_din0, 16'd45);
      check("t1_latency", last_gap, 2);
      check("t1_writes", writes0 - wbase, 1);

      // 2: negative products
      load_const(16'hfffd, 16'd2);
      feed(9, 0);
      drain();
      check("t2_din", last_din0, 16'hffca);

      // 3: rescale plus output backpressure
      load_const(16'd256, 16'd256);
      output_V_full_n = 1'b0;
      wbase = writes0;
      feed(9, 0);
      @(posedge clk); #1;
      input_V_empty_n  = 1'b1;
      weight_V_empty_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("t3_hold_write", wo8, 1'b0);
         check("t3_hold_read", {ir0, wr0}, 2'b00);
         check("t3_hold_din", din8, 16'd2304);
         @(posedge clk); #1;
      end
      input_V_empty_n  = 1'b0;
      weight_V_empty_n = 1'b0;
      drain();
      check("t3_din", last_din8, 16'd2304);
      check("t3_writes", writes0 - wbase, 1);

      // 4: weight FIFO toggling, same data as test 1
      for (int i = 0; i < 9; i++) begin
         act_v[i] = 16'd1;
         wt_v[i]  = 16'(i + 1);
      end
      feed(9, 1);
      drain();
      check("t4_din", last_din0, 16'd45);

      // 5: overflow of the output width
      load_const(16'd32767, 16'd32767);
      feed(9, 0);
      drain();
`ifdef CONV_MAC_SAT_EN
      check("t5_din", last_din0, 16'h7fff);
`else
      check("t5_din", last_din0, 16'd9);
`endif

      // 6: reset mid-window discards the partial sum
      load_const(16'd1, 16'd1);
      wbase = writes0;
      feed(4, 0);
      ap_rst = 1'b1;
      @(posedge clk); #1;
      ap_rst = 1'b0;
      check("t6_no_write", writes0 - wbase, 0);
      feed(9, 0);
      drain();
      check("t6_din", last_din0, 16'd9);
      check("t6_writes", writes0 - wbase, 1);

      // Random windows with random flow control
      for (int r = 0; r < 20; r++) begin
         for (int i = 0; i < 9; i++) begin
            act_v[i] = 16'($urandom_range(0, 65535));
            wt_v[i]  = 16'($urandom_range(0, 65535));
         end
         feed(9, 2);
      end
      drain();
      check("rand_left0", exp_q0.size(), 0);
      check("rand_left8", exp_q8.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
